// File: rtl/control_pipe_if.sv
// control_pipe_if: fetch-side and execute-side handshake bundle for control_pipe
interface control_pipe_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [23:0] ctrl;
  logic        illegal;
  logic        flush;
  modport master (
    output instr_valid, instr, ctrl_ready, flush,
    input  instr_ready, ctrl_valid, ctrl, illegal
  );
  modport slave (
    input  instr_valid, instr, ctrl_ready, flush,
    output instr_ready, ctrl_valid, ctrl, illegal
  );
endinterface

// File: rtl/control_pipe.sv
// control_pipe: registered instruction decoder with load-use and multiplier issue interlock
module control_pipe #(
  parameter int GROUP    = 4,
  parameter int MULT_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  control_pipe_if.slave bus
);
  localparam int CW = $clog2(MULT_LAT + 1);
  typedef enum logic [1:0] {RUN, BUBBLE, MUL_WAIT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] mul_cnt_q, mul_cnt_d;
  logic          lw_pending_q, lw_pending_d;
  logic [4:0]    lw_dest_q, lw_dest_d;
  logic          ctrl_valid_q, ctrl_valid_d;
  logic [23:0]   ctrl_q, ctrl_d;
  logic          illegal_q, illegal_d;
  logic [5:0]    op, fn;
  logic [4:0]    rs, rt;
  logic [1:0]    alu;
  logic [23:0]   dec;
  logic          is_lw, is_sw, r_ok, is_mul, mem, can_load, hz, ready, acc, bubble, mul_go;
  always_comb begin
    op       = bus.instr[31:26];
    fn       = bus.instr[5:0];
    rs       = bus.instr[25:21];
    rt       = bus.instr[20:16];
    is_lw    = op == 6'(GROUP + 1);
    is_sw    = op == 6'(GROUP + 2);
    r_ok     = op == 6'(GROUP) && bus.instr[10:6] == 5'd10 &&
               (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd50);
    is_mul   = r_ok && fn == 6'd50;
    mem      = is_lw || is_sw;
    alu      = !r_ok ? 2'd0 : fn == 6'd34 ? 2'd1 : fn == 6'd36 ? 2'd2 : fn == 6'd37 ? 2'd3 : 2'd0;
    dec      = {is_lw || r_ok, alu, mem, mem, !is_mul, mem, is_lw || r_ok, is_mul, rs, rt,
                is_lw ? rt : r_ok ? bus.instr[15:11] : 5'd0};
    can_load = !ctrl_valid_q || bus.ctrl_ready;
    hz       = bus.instr_valid && lw_pending_q && lw_dest_q != 5'd0 && (rs == lw_dest_q || rt == lw_dest_q);
    ready    = state_q == RUN && can_load && !hz && !bus.flush;
    acc      = bus.instr_valid && ready;
    bubble   = state_q == RUN && hz && can_load && !bus.flush;
    mul_go   = acc && is_mul && MULT_LAT > 1;
    ctrl_valid_d = bus.flush ? 1'b0 : acc ? 1'b1 : bus.ctrl_ready ? 1'b0 : ctrl_valid_q;
    ctrl_d       = acc ? dec : ctrl_q;
    illegal_d    = bus.flush ? 1'b0 : acc ? !(mem || r_ok) : illegal_q;
    state_d      = bus.flush ? RUN : mul_go ? MUL_WAIT : bubble ? BUBBLE :
                   (state_q == MUL_WAIT && mul_cnt_q > CW'(1)) ? MUL_WAIT : RUN;
    mul_cnt_d    = bus.flush ? '0 : mul_go ? CW'(MULT_LAT - 1) :
                   mul_cnt_q > CW'(1) ? mul_cnt_q - CW'(1) : '0;
    lw_pending_d = (bus.flush || bubble) ? 1'b0 : acc ? is_lw : lw_pending_q;
    lw_dest_d    = (bus.flush || bubble) ? 5'd0 : acc ? rt : lw_dest_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      mul_cnt_q    <= '0;
      lw_pending_q <= 1'b0;
      lw_dest_q    <= 5'd0;
      ctrl_valid_q <= 1'b0;
      ctrl_q       <= 24'd0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mul_cnt_q    <= mul_cnt_d;
      lw_pending_q <= lw_pending_d;
      lw_dest_q    <= lw_dest_d;
      ctrl_valid_q <= ctrl_valid_d;
      ctrl_q       <= ctrl_d;
      illegal_q    <= illegal_d;
    end
  end
  assign bus.instr_ready = ready;
  assign bus.ctrl_valid  = ctrl_valid_q;
  assign bus.ctrl        = ctrl_q;
  assign bus.illegal     = illegal_q;
endmodule
